// File: rtl/regfile_acc_writer.sv
// regfile_acc_writer
//
// Write-port arbiter between the processor writeback stage and the register
// file write port. Accelerator writes to the mailbox registers r26..r29 are
// buffered in a small FIFO and drained into writeback slots the processor
// leaves free. A head entry that stays blocked for StarveLimit cycles forces
// a one-cycle processor stall, during which the head is written.
//
// Ports:
//   clock            system clock, rising edge
//   ctrl_reset_n     synchronous active-low reset; forces all outputs to 0
//   proc_writeEnable processor writeback request
//   proc_writeReg    processor destination register
//   proc_writeData   processor writeback data
//   acc_valid        accelerator write request valid
//   acc_ready        an accelerator write can be accepted this cycle
//   acc_reg          accelerator target offset (destination = 26 + acc_reg)
//   acc_data         accelerator write data
//   ctrl_writeEnable register file write enable
//   ctrl_writeReg    register file write select
//   data_writeReg    register file write data
//   proc_stall       processor must hold its writeback this cycle
//   acc_pending      bit k set while any queued entry targets r(26+k)
//   overrun          sticky; processor wrote during a stall cycle
module regfile_acc_writer #(
  parameter int unsigned FifoDepth   = 2,
  parameter int unsigned StarveLimit = 8
) (
  input  logic        clock,
  input  logic        ctrl_reset_n,
  input  logic        proc_writeEnable,
  input  logic [4:0]  proc_writeReg,
  input  logic [31:0] proc_writeData,
  input  logic        acc_valid,
  output logic        acc_ready,
  input  logic [1:0]  acc_reg,
  input  logic [31:0] acc_data,
  output logic        ctrl_writeEnable,
  output logic [4:0]  ctrl_writeReg,
  output logic [31:0] data_writeReg,
  output logic        proc_stall,
  output logic [3:0]  acc_pending,
  output logic        overrun
);

  localparam int unsigned PtrW    = $clog2(FifoDepth);
  localparam int unsigned CntW    = $clog2(FifoDepth + 1);
  localparam int unsigned StarveW = $clog2(StarveLimit + 1);

  logic [1:0]         off_q  [FifoDepth];
  logic [31:0]        data_q [FifoDepth];
  logic [PtrW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]    count_q;
  logic [StarveW-1:0] starve_q;
  logic               stall_q, overrun_q;

  logic head_valid, full, push, pop;
  logic grant_proc, grant_head;

  always_comb begin
    full       = (count_q == CntW'(FifoDepth));
    head_valid = (count_q != '0);
    grant_proc = 1'b0;
    grant_head = 1'b0;
    if (ctrl_reset_n) begin
      // A forced stall outranks the processor; writes to r0 are no-ops and
      // leave the slot free for the head.
      if (stall_q && head_valid) begin
        grant_head = 1'b1;
      end else if (proc_writeEnable && (proc_writeReg != 5'd0)) begin
        grant_proc = 1'b1;
      end else if (head_valid) begin
        grant_head = 1'b1;
      end
    end
    acc_ready = ctrl_reset_n & ~full;
    push      = acc_valid & acc_ready;
    pop       = grant_head;
  end

  always_comb begin
    ctrl_writeEnable = grant_proc | grant_head;
    ctrl_writeReg    = 5'd0;
    data_writeReg    = 32'd0;
    if (grant_proc) begin
      ctrl_writeReg = proc_writeReg;
      data_writeReg = proc_writeData;
    end else if (grant_head) begin
      ctrl_writeReg = 5'd26 + {3'b000, off_q[rd_ptr_q]};
      data_writeReg = data_q[rd_ptr_q];
    end
  end

  always_comb begin
    acc_pending = 4'b0000;
    for (int unsigned i = 0; i < FifoDepth; i++) begin
      if (CntW'(i) < count_q) begin
        acc_pending[off_q[rd_ptr_q + PtrW'(i)]] = 1'b1;
      end
    end
    if (!ctrl_reset_n) begin
      acc_pending = 4'b0000;
    end
  end

  assign proc_stall = ctrl_reset_n & stall_q;
  assign overrun    = ctrl_reset_n & overrun_q;

  // Storage needs no reset; validity is tracked by count_q.
  always_ff @(posedge clock) begin
    if (push) begin
      off_q[wr_ptr_q]  <= acc_reg;
      data_q[wr_ptr_q] <= acc_data;
    end
  end

  always_ff @(posedge clock) begin
    if (!ctrl_reset_n) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      starve_q  <= '0;
      stall_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CntW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CntW'(1);
      end

      // The head is always granted during a stall cycle, so the pop path
      // clears the counter and stall cannot repeat back-to-back.
      stall_q <= 1'b0;
      if (pop || !head_valid) begin
        starve_q <= '0;
      end else if (starve_q == StarveW'(StarveLimit - 1)) begin
        starve_q <= '0;
        stall_q  <= 1'b1;
      end else begin
        starve_q <= starve_q + StarveW'(1);
      end

      if (stall_q && head_valid && proc_writeEnable) begin
        overrun_q <= 1'b1;
      end
    end
  end

endmodule

// File: doc/regfile_acc_writer.md
# regfile_acc_writer

Write-port arbiter that lets the boid accelerator write results back into the processor register file's mailbox registers r26–r29. It sits between the processor writeback stage and the register file write port (`ctrl_writeEnable` / `ctrl_writeReg` / `data_writeReg`). It buffers accelerator writes in a small FIFO and drains them into free writeback slots. If the processor starves the FIFO, it forces a one-cycle processor stall.

## Interface
Parameters:
- FIFO_DEPTH, 2, accelerator write buffer entries; power of two, ≥2
- STARVE_LIMIT, 8, consecutive blocked cycles before a forced stall; ≥1

Ports:
- clock  in  1  system clock, rising edge
- ctrl_reset_n  in  1  reset: one clock; reset is synchronous and active-low
- proc_writeEnable  in  1  processor writeback request
- proc_writeReg  in  5  processor destination register
- proc_writeData  in  32  processor writeback data
- acc_valid  in  1  accelerator write request valid
- acc_ready  out  1  block can accept an accelerator write
- acc_reg  in  2  target offset; destination = 26 + acc_reg
- acc_data  in  32  accelerator write data
- ctrl_writeEnable  out  1  to register file write enable
- ctrl_writeReg  out  5  to register file write select
- data_writeReg  out  32  to register file write data
- proc_stall  out  1  processor must hold writeback this cycle
- acc_pending  out  4  bit k set while any FIFO entry targets r(26+k)
- overrun  out  1  sticky; processor wrote during a stall cycle

## Operation
- FIFO: circular buffer of {offset[1:0], data[31:0]}, FIFO_DEPTH entries, with read/write pointers plus a count.
- Push on a rising edge when acc_valid & acc_ready.
- acc_ready = ctrl_reset_n & (count != FIFO_DEPTH). It is never high when full, and there is no same-cycle push-through.
- No bypass: an accepted entry becomes head no earlier than the next cycle.
- Grant rule (combinational, per cycle; head valid = count != 0):
  - proc_stall=1 and head valid → head granted. Processor inputs are ignored. If proc_writeEnable=1 in that cycle, overrun is set (sticky until reset).
  - else proc_writeEnable=1 and proc_writeReg != 0 → processor granted.
  - else head valid → head granted (this includes proc_writeEnable=1 with proc_writeReg=0, a no-op write).
  - else idle.
- Outputs by grant:
  - Processor granted → ctrl_writeEnable=1, ctrl_writeReg=proc_writeReg, data_writeReg=proc_writeData.
  - Head granted → ctrl_writeEnable=1, ctrl_writeReg=26+offset, data_writeReg=head data. Pop on the edge.
  - Idle → ctrl_writeEnable=0; ctrl_writeReg and data_writeReg = 0.
- Simultaneous push and pop (count not full): count unchanged, both pointers advance.
- Starvation counter (width clog2(STARVE_LIMIT+1)):
  - Increments each cycle the head is valid and not granted.
  - Clears on any pop or when the FIFO is empty.
  - When it equals STARVE_LIMIT at an edge, proc_stall is registered high for exactly the next cycle and the counter clears.
  - proc_stall never asserts on two consecutive cycles.
- acc_pending: OR over valid FIFO entries of onehot(offset). Combinational from the FIFO state; it clears in the cycle after the last matching pop.
- Same-register collision: a processor write to r26–r29 while the head targets the same register goes to the processor; the head stays queued and overwrites later. Ordering between the two sources is the arbitration order; there is no merging.

## Timing
- Reset: when ctrl_reset_n=0 at an edge, the block clears count, both pointers, the starvation counter, proc_stall and overrun.
- While ctrl_reset_n=0, all outputs are forced to 0: acc_ready, ctrl_writeEnable, ctrl_writeReg, data_writeReg, proc_stall, acc_pending and overrun.
- Reset mid-operation discards queued entries with no write issued.
- Processor writeback path: zero latency, purely combinational pass-through.
- Accelerator path:
  - Minimum latency is 1 cycle: accepted at edge E0, ctrl_writeEnable in cycle E0→E1, register written at E1.
  - Worst case, the head is written within STARVE_LIMIT+1 cycles of becoming head.
- acc_ready deasserts in the cycle after the push that fills the FIFO. It reasserts in the cycle after the pop that frees an entry.
- overrun updates at the edge ending the offending stall cycle.

## Test plan
- Idle processor; push (acc_reg=2, data=0xDEADBEEF) → next cycle ctrl_writeEnable=1, ctrl_writeReg=28, data_writeReg=0xDEADBEEF; acc_pending=0b0100 for one cycle, then 0.
- Processor writes r5=0x11 every cycle; push offset 0 → stays blocked 8 cycles, then proc_stall=1 for one cycle with ctrl_writeReg=26, then processor writes resume; overrun=1 because the processor kept writing.
- Two pushes back-to-back with the processor busy → acc_ready=0 after the second; a third acc_valid is held, not accepted, until a pop frees a slot.
- Processor writes r0 every cycle, FIFO holds 2 entries (offsets 1, 3) → r27 then r29 written on consecutive cycles; proc_stall never asserts.
- Processor writes r26=0xAAAA while the head targets r26 with 0xBBBB → 0xAAAA written first, 0xBBBB on the next free slot.
- FIFO full, ctrl_reset_n=0 for one cycle → outputs 0 in the reset cycle; afterwards count=0, acc_ready=1, and no accelerator write is issued.
